pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Reset sequencer that sits directly downstream of the system PLL. It consumes the PLL `locked` flag and generates sequenced, synchronous, active-low resets for the SDRAM controller and for the rest of the SoC. Resets are released only after lock has been continuously stable for a programmable time. Resets are re-asserted immediately on loss of lock. Runs in the `clkout_system` domain.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before `sdram_rst_n` is released (≥1).
- `SYS_DELAY_CYCLES`, default 16: cycles between the release of `sdram_rst_n` and the release of `sys_rst_n` (≥1).
- `SYNC_STAGES`, default 2: synchronizer depth for `pll_locked` (≥2).
- `BTN_FILTER_CYCLES`, default 16: consecutive low cycles required on synchronized `btn_n` (used only with `RSTSEQ_BUTTON_EN`).

Ports:
- `clk`  in  1  system clock (PLL `clkout_system`).
- `rst_n`  in  1  reset, synchronous, active-low.
- `pll_locked`  in  1  PLL lock flag, asynchronous to `clk`.
- `btn_n`  in  1  external reset button, active-low, asynchronous (present only with `RSTSEQ_BUTTON_EN`).
- `sdram_rst_n`  out  1  SDRAM controller reset, active-low, registered.
- `sys_rst_n`  out  1  SoC reset, active-low, registered.
- `lock_loss_cnt`  out  8  saturating count of lock losses after release.

## Operation
- `pll_locked` passes through a `SYNC_STAGES`-flop synchronizer to give `lock_s`. The counter is sized to `clog2(max(LOCK_STABLE_CYCLES, SYS_DELAY_CYCLES))`.
- Reset (`rst_n`=0 at an edge): state LOCK_WAIT, count 0, synchronizer flops 0, `sdram_rst_n`=0, `sys_rst_n`=0, `lock_loss_cnt`=0. This takes precedence over all other events.
- LOCK_WAIT: both resets low.
  - `lock_s`=0 → count cleared.
  - `lock_s`=1 → count increments.
  - `lock_s`=1 and count==`LOCK_STABLE_CYCLES`-1 → SDRAM_REL; count cleared; `sdram_rst_n`←1.
- SDRAM_REL: `sdram_rst_n`=1, `sys_rst_n`=0, and count increments. When count==`SYS_DELAY_CYCLES`-1 → RUN and `sys_rst_n`←1.
- RUN: both resets high. The state holds while `lock_s`=1.
- Lock loss (`lock_s`=0 in SDRAM_REL or RUN):
  - next state LOCK_WAIT, count cleared;
  - both resets ←0 at the same edge;
  - `lock_loss_cnt` increments, saturating at 255.
- A lock glitch during LOCK_WAIT only restarts the stability count; `lock_loss_cnt` is unchanged.
- Lock loss has priority over the SDRAM_REL→RUN transition in the same cycle.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Release latency: with `pll_locked` high from the first sampling edge (edge 1), `sdram_rst_n` is high after edge `SYNC_STAGES`+`LOCK_STABLE_CYCLES`. `sys_rst_n` rises exactly `SYS_DELAY_CYCLES` edges after `sdram_rst_n`.
- Assert latency: a `pll_locked` fall is seen on `lock_s` after `SYNC_STAGES` edges. Both resets are low at the following edge (`SYNC_STAGES`+1 edges).
- Both resets always assert together; `sys_rst_n` is never high while `sdram_rst_n` is low.

## Configuration
- `RSTSEQ_BUTTON_EN` defined:
  - The `btn_n` port exists and is synchronized by 2 flops.
  - A filter counter requires `BTN_FILTER_CYCLES` consecutive synchronized-low cycles to register a press; any high sample clears the counter.
  - A filtered press forces LOCK_WAIT, clears count, and drives both resets low. It does not increment `lock_loss_cnt`.
  - The sequencer is held in LOCK_WAIT with count 0 while the filtered button stays low. The sequence restarts on release.
  - A press and a lock loss in the same cycle increment `lock_loss_cnt` once.
- `RSTSEQ_BUTTON_EN` undefined: no `btn_n` port, no button logic, and `BTN_FILTER_CYCLES` is ignored.

## Test plan
Benches use `LOCK_STABLE_CYCLES`=8, `SYS_DELAY_CYCLES`=4, `SYNC_STAGES`=2.
- Power-up release: `rst_n` low 3 cycles, then high, with `pll_locked`=1 held → `sdram_rst_n` rises after edge 10 and `sys_rst_n` after edge 14. `lock_loss_cnt`=0.
- Lock glitch before release: `pll_locked` low for 1 cycle at edge 6 → count restarts; release is delayed accordingly. `lock_loss_cnt` stays 0.
- Loss in RUN: drop `pll_locked` → both resets low 3 edges later and `lock_loss_cnt`=1. Restore lock → full 10+4 sequence repeats.
- Saturation: 300 lock-loss/relock cycles → `lock_loss_cnt`=255.
- Mid-sequence reset: `rst_n` low during SDRAM_REL → both outputs 0 and counter 0 at that edge. Release restarts from LOCK_WAIT.
- Button (`RSTSEQ_BUTTON_EN`, filter 16): a 15-cycle `btn_n` pulse has no effect. A 20-cycle pulse drives both resets low, leaves `lock_loss_cnt` unchanged, and restarts the sequence after release.

Source files
------------

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: turns the PLL lock flag into two sequenced, synchronous,
// active-low resets. sdram_rst_n is released once lock has been stable for
// LOCK_STABLE_CYCLES cycles. sys_rst_n follows SYS_DELAY_CYCLES later. Both
// resets drop together as soon as lock is lost.
// Optional feature macro: RSTSEQ_BUTTON_EN adds a filtered btn_n reset input.
module pll_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SYS_DELAY_CYCLES   = 16,
  parameter int SYNC_STAGES        = 2,
  parameter int BTN_FILTER_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
`ifdef RSTSEQ_BUTTON_EN
  input  logic       btn_n,
`endif
  output logic       sdram_rst_n,
  output logic       sys_rst_n,
  output logic [7:0] lock_loss_cnt
);

  // A single counter serves both the lock-stability wait and the
  // SDRAM-to-system delay, so it is sized for the longer of the two.
  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > SYS_DELAY_CYCLES) ?
                           LOCK_STABLE_CYCLES : SYS_DELAY_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST  = CNT_W'(SYS_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    LOCK_WAIT = 2'd0,
    SDRAM_REL = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   btn_press;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   sdram_q, sdram_d;
  logic                   sys_q, sys_d;
  logic [7:0]             loss_q, loss_d;
  logic                   lock_lost;

  // Bring the asynchronous lock flag into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

`ifdef RSTSEQ_BUTTON_EN
  localparam int BTN_W = (BTN_FILTER_CYCLES > 0) ? $clog2(BTN_FILTER_CYCLES + 1) : 1;
  localparam logic [BTN_W-1:0] BTN_FULL = BTN_W'(BTN_FILTER_CYCLES);
  localparam logic [BTN_W-1:0] BTN_ONE  = BTN_W'(1);

  logic [1:0]       btn_sync_q;
  logic [BTN_W-1:0] btn_cnt_q;

  // Synchronize the button and count consecutive low samples; the count
  // parks at BTN_FULL so a held press stays asserted until release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_sync_q <= 2'b11;
      btn_cnt_q  <= '0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], btn_n};
      if (btn_sync_q[1]) begin
        btn_cnt_q <= '0;
      end else if (btn_cnt_q != BTN_FULL) begin
        btn_cnt_q <= btn_cnt_q + BTN_ONE;
      end
    end
  end

  assign btn_press = (btn_cnt_q == BTN_FULL);
`else
  logic unused_btn_filter;
  assign unused_btn_filter = (BTN_FILTER_CYCLES != 0);
  assign btn_press         = 1'b0;
`endif

  // Next-state logic: lock loss and button press win over every sequencing step.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sdram_d   = sdram_q;
    sys_d     = sys_q;
    loss_d    = loss_q;
    lock_lost = !lock_s && (state_q != LOCK_WAIT);

    // Losses are only counted once the SDRAM reset had been released; a
    // simultaneous button press still counts the loss exactly once.
    if (lock_lost && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end

    if (lock_lost || btn_press) begin
      state_d = LOCK_WAIT;
      count_d = '0;
      sdram_d = 1'b0;
      sys_d   = 1'b0;
    end else begin
      case (state_q)
        LOCK_WAIT: begin
          sdram_d = 1'b0;
          sys_d   = 1'b0;
          if (!lock_s) begin
            count_d = '0;
          end else if (count_q == LOCK_LAST) begin
            state_d = SDRAM_REL;
            count_d = '0;
            sdram_d = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        SDRAM_REL: begin
          sdram_d = 1'b1;
          sys_d   = 1'b0;
          if (count_q == SYS_LAST) begin
            state_d = RUN;
            count_d = '0;
            sys_d   = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        RUN: begin
          sdram_d = 1'b1;
          sys_d   = 1'b1;
        end
        default: begin
          state_d = LOCK_WAIT;
          count_d = '0;
          sdram_d = 1'b0;
          sys_d   = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, counter and registered reset outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOCK_WAIT;
      count_q <= '0;
      sdram_q <= 1'b0;
      sys_q   <= 1'b0;
      loss_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sdram_q <= sdram_d;
      sys_q   <= sys_d;
      loss_q  <= loss_d;
    end
  end

  assign sdram_rst_n   = sdram_q;
  assign sys_rst_n     = sys_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq. The reference model tracks how many
// consecutive edges have seen synchronized lock high: sdram_rst_n is high once
// that run reaches LOCK_STABLE_CYCLES, sys_rst_n once it reaches
// LOCK_STABLE_CYCLES + SYS_DELAY_CYCLES. Define RSTSEQ_BUTTON_EN to also
// exercise the button input.
module tb_pll_reset_seq;

  localparam int LSC = 8;
  localparam int SDC = 4;
  localparam int SS  = 2;
  localparam int BF  = 16;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b0;
  logic       btn_n      = 1'b1;
  logic       sdram_rst_n;
  logic       sys_rst_n;
  logic [7:0] lock_loss_cnt;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .LOCK_STABLE_CYCLES(LSC),
    .SYS_DELAY_CYCLES  (SDC),
    .SYNC_STAGES       (SS),
    .BTN_FILTER_CYCLES (BF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
`ifdef RSTSEQ_BUTTON_EN
    .btn_n        (btn_n),
`endif
    .sdram_rst_n  (sdram_rst_n),
    .sys_rst_n    (sys_rst_n),
    .lock_loss_cnt(lock_loss_cnt)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Reference model state.
  bit lock_pipe[$];
  bit btn_pipe[$];
  int run_m;
  int loss_m;
  int brun_m;

  task automatic model_reset();
    lock_pipe.delete();
    for (int i = 0; i < SS; i++) lock_pipe.push_back(1'b0);
    btn_pipe.delete();
    btn_pipe.push_back(1'b1);
    btn_pipe.push_back(1'b1);
    run_m  = 0;
    loss_m = 0;
    brun_m = 0;
  endtask

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_edge();
    bit seen;
    bit press;
    if (!rst_n) begin
      model_reset();
      return;
    end
    seen = lock_pipe.pop_front();
    lock_pipe.push_back(pll_locked);
    press = 1'b0;
`ifdef RSTSEQ_BUTTON_EN
    begin
      bit bseen;
      bseen = btn_pipe.pop_front();
      btn_pipe.push_back(btn_n);
      press  = (brun_m >= BF);
      brun_m = bseen ? 0 : brun_m + 1;
    end
`endif
    if (!seen) begin
      if (run_m >= LSC) loss_m = (loss_m < 255) ? loss_m + 1 : 255;
      run_m = 0;
    end else if (press) begin
      run_m = 0;
    end else begin
      run_m++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_sdram_rst_n", sdram_rst_n, (run_m >= LSC) ? 1 : 0);
    chk("model_sys_rst_n", sys_rst_n, (run_m >= LSC + SDC) ? 1 : 0);
    chk("model_lock_loss_cnt", lock_loss_cnt, loss_m);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    model_reset();

    // Reset state with lock already present.
    rst_n = 1'b0; pll_locked = 1'b1; btn_n = 1'b1;
    ticks(3);
    chk("reset_sdram", sdram_rst_n, 0);
    chk("reset_sys", sys_rst_n, 0);
    chk("reset_loss", lock_loss_cnt, 0);

    // Power-up release: sdram after edge 10, sys after edge 14.
    rst_n = 1'b1;
    ticks(9);
    chk("pwr_sdram_e9", sdram_rst_n, 0);
    tick();
    chk("pwr_sdram_e10", sdram_rst_n, 1);
    ticks(3);
    chk("pwr_sys_e13", sys_rst_n, 0);
    tick();
    chk("pwr_sys_e14", sys_rst_n, 1);
    chk("pwr_loss", lock_loss_cnt, 0);

    // Lock glitch at edge 6 restarts the stability count.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(5);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    ticks(9);
    chk("glitch_sdram_e15", sdram_rst_n, 0);
    tick();
    chk("glitch_sdram_e16", sdram_rst_n, 1);
    ticks(8);
    chk("glitch_sys", sys_rst_n, 1);
    chk("glitch_loss", lock_loss_cnt, 0);

    // Lock loss in RUN: resets drop on the third edge.
    pll_locked = 1'b0;
    ticks(2);
    chk("loss_sdram_e2", sdram_rst_n, 1);
    tick();
    chk("loss_sdram_e3", sdram_rst_n, 0);
    chk("loss_sys_e3", sys_rst_n, 0);
    chk("loss_cnt_e3", lock_loss_cnt, 1);
    pll_locked = 1'b1;
    ticks(9);
    chk("relock_sdram_e9", sdram_rst_n, 0);
    tick();
    chk("relock_sdram_e10", sdram_rst_n, 1);
    ticks(3);
    chk("relock_sys_e13", sys_rst_n, 0);
    tick();
    chk("relock_sys_e14", sys_rst_n, 1);

    // Randomized lock activity.
    repeat (40) begin
      pll_locked = 1'($urandom_range(0, 1));
      ticks(int'($urandom_range(1, 20)));
    end

    // Saturation of the loss counter.
    repeat (300) begin
      pll_locked = 1'b1;
      ticks(12);
      pll_locked = 1'b0;
      ticks(3);
    end
    chk("sat_loss", lock_loss_cnt, 255);

    // Reset in the middle of SDRAM_REL.
    pll_locked = 1'b1;
    ticks(11);
    chk("mid_sdram_rel_sdram", sdram_rst_n, 1);
    chk("mid_sdram_rel_sys", sys_rst_n, 0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_sdram", sdram_rst_n, 0);
    chk("mid_rst_sys", sys_rst_n, 0);
    chk("mid_rst_loss", lock_loss_cnt, 0);
    rst_n = 1'b1;
    ticks(10);
    chk("mid_restart_sdram", sdram_rst_n, 1);
    ticks(4);
    chk("mid_restart_sys", sys_rst_n, 1);

`ifdef RSTSEQ_BUTTON_EN
    // A 15-cycle press is filtered out.
    btn_n = 1'b0;
    ticks(15);
    btn_n = 1'b1;
    ticks(5);
    chk("btn15_sdram", sdram_rst_n, 1);
    chk("btn15_sys", sys_rst_n, 1);
    chk("btn15_loss", lock_loss_cnt, 0);
    // A 20-cycle press resets and the sequence restarts on release.
    btn_n = 1'b0;
    ticks(20);
    chk("btn20_sdram", sdram_rst_n, 0);
    chk("btn20_sys", sys_rst_n, 0);
    chk("btn20_loss", lock_loss_cnt, 0);
    btn_n = 1'b1;
    ticks(20);
    chk("btn20_rel_sdram", sdram_rst_n, 1);
    chk("btn20_rel_sys", sys_rst_n, 1);
    chk("btn20_rel_loss", lock_loss_cnt, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
